// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the five-stage MIPS core.
// Holds decoded operands and control for the EX stage, detects load-use and
// branch-in-ID hazards, inserts bubbles and drives stall to freeze PC and IF/ID.
// Flush squashes the ID instruction; hold freezes the whole stage.
module id_ex_stage_reg (
  input  logic        clk,
  input  logic        rst_n,

  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_branch,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic [3:0]  id_aluop,

  input  logic        flush,
  input  logic        hold,

  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_write_reg,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_alusrc,
  output logic [3:0]  ex_aluop,
  output logic        ex_valid,
  output logic        stall
);

  // RUN: normal operation. STALL2: second bubble of a branch waiting on a load.
  typedef enum logic {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } state_e;

  // Everything the EX slot carries; a bubble is the all-zero value.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
  } ex_slot_t;

  localparam ex_slot_t BUBBLE = '0;

  state_e   state_q, state_d;
  ex_slot_t ex_q, ex_d;
  ex_slot_t id_slot;

  logic ex_dest_live;
  logic src_match;
  logic lu_hit;
  logic bh_hit;

  // Pack the ID instruction into the slot format, resolving the destination.
  always_comb begin
    id_slot           = BUBBLE;
    id_slot.valid     = 1'b1;
    id_slot.rs        = id_rs;
    id_slot.rt        = id_rt;
    id_slot.write_reg = id_regdst ? id_rd : id_rt;
    id_slot.rd1       = id_rd1;
    id_slot.rd2       = id_rd2;
    id_slot.imm       = id_imm;
    id_slot.regwrite  = id_regwrite;
    id_slot.memread   = id_memread;
    id_slot.memwrite  = id_memwrite;
    id_slot.memtoreg  = id_memtoreg;
    id_slot.alusrc    = id_alusrc;
    id_slot.aluop     = id_aluop;
  end

  // Hazard detection against the instruction currently sitting in EX.
  // A bubble carries write_reg 0, and r0 is never a real dependency.
  assign ex_dest_live = ex_q.valid && (ex_q.write_reg != 5'd0);
  assign src_match    = (id_uses_rs && (id_rs == ex_q.write_reg)) ||
                        (id_uses_rt && (id_rt == ex_q.write_reg));
  assign lu_hit       = ex_dest_live && ex_q.memread && src_match;
  assign bh_hit       = id_branch && ex_dest_live && ex_q.regwrite && src_match;

  // Next-state, next slot contents and the Mealy stall output.
  // Priority: flush > hold > hazard > normal capture.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    ex_d    = ex_q;
    stall   = 1'b0;

    if (flush) begin
      ex_d    = BUBBLE;
      state_d = RUN;
    end else if (hold) begin
      stall = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bh_hit && ex_q.memread) begin
            // Branch needs a load result: two bubbles before it is in the RF.
            stall   = 1'b1;
            ex_d    = BUBBLE;
            state_d = STALL2;
          end else if (lu_hit || bh_hit) begin
            stall = 1'b1;
            ex_d  = BUBBLE;
          end else begin
            ex_d = id_slot;
          end
        end
        STALL2: begin
          stall   = 1'b1;
          ex_d    = BUBBLE;
          state_d = RUN;
        end
        default: begin
          ex_d    = BUBBLE;
          state_d = RUN;
        end
      endcase
    end
  end

  // State and EX slot registers with asynchronous reset to RUN / bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ex_q    <= BUBBLE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_write_reg = ex_q.write_reg;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_aluop     = ex_q.aluop;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg. Inputs change on the falling edge;
// outputs and the combinational stall are sampled 1 ns later.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_branch;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst;
  logic [3:0]  id_aluop;
  logic        flush, hold;
  logic [4:0]  ex_rs, ex_rt, ex_write_reg;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [3:0]  ex_aluop;
  logic        ex_valid, stall;

  int vec_cnt = 0;
  int err_cnt = 0;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_aluop(id_aluop), .flush(flush), .hold(hold),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_valid(ex_valid), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_id();
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_branch = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0; id_alusrc = 0; id_regdst = 0; id_aluop = 0;
    flush = 0; hold = 0;
  endtask

  // R-type ALU op: rd <- rs op rt.
  task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
    idle_id();
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1; id_uses_rt = 1;
    id_rd1 = d1; id_rd2 = d2; id_regwrite = 1; id_regdst = 1; id_aluop = 4'd2;
  endtask

  // lw rt, imm(rs).
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    idle_id();
    id_rs = rs; id_rt = rt; id_uses_rs = 1; id_imm = imm;
    id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1;
  endtask

  // beq rs, rt.
  task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt);
    idle_id();
    id_rs = rs; id_rt = rt; id_uses_rs = 1; id_uses_rt = 1; id_branch = 1; id_aluop = 4'd6;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_id();
    next_cycle(); #1;
    vec_cnt++; if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b want 0", stall); end
    vec_cnt++; if ({ex_rs, ex_rt, ex_write_reg, ex_aluop} !== 19'd0) begin err_cnt++; $display("FAIL reset_fields: got %h want 0", {ex_rs, ex_rt, ex_write_reg, ex_aluop}); end
    vec_cnt++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'd0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", {ex_rd1, ex_rd2, ex_imm}); end
    vec_cnt++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc} !== 5'd0) begin err_cnt++; $display("FAIL reset_ctrl: got %b want 0", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc}); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_plain_capture();
    set_alu(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL add_stall: got %b want 0", stall); end
    next_cycle(); #1;
    vec_cnt++; if (ex_write_reg !== 5'd3) begin err_cnt++; $display("FAIL add_wreg: got %0d want 3", ex_write_reg); end
    vec_cnt++; if (ex_valid !== 1'b1) begin err_cnt++; $display("FAIL add_valid: got %b want 1", ex_valid); end
    vec_cnt++; if ({ex_rs, ex_rt} !== {5'd1, 5'd2}) begin err_cnt++; $display("FAIL add_src: got %0d,%0d want 1,2", ex_rs, ex_rt); end
    vec_cnt++; if ({ex_rd1, ex_rd2, ex_aluop} !== {32'h11, 32'h22, 4'd2}) begin err_cnt++; $display("FAIL add_data: got %h %h %h want 11 22 2", ex_rd1, ex_rd2, ex_aluop); end
    vec_cnt++; if (ex_regwrite !== 1'b1) begin err_cnt++; $display("FAIL add_regwrite: got %b want 1", ex_regwrite); end
  endtask

  task automatic test_load_use();
    set_lw(5'd1, 5'd5, 32'h4);
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
    next_cycle();
    set_alu(5'd5, 5'd6, 5'd7, 32'h55, 32'h66);
    #1;
    vec_cnt++; if ({ex_write_reg, ex_memread, ex_alusrc} !== {5'd5, 1'b1, 1'b1}) begin err_cnt++; $display("FAIL lu_lw_in_ex: got %0d %b %b want 5 1 1", ex_write_reg, ex_memread, ex_alusrc); end
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL lu_stall: got %b want 1", stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_regwrite, ex_write_reg} !== 7'd0) begin err_cnt++; $display("FAIL lu_bubble: got %b %b %0d want 0 0 0", ex_valid, ex_regwrite, ex_write_reg); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL lu_stall_len: got %b want 0", stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_rs, ex_write_reg} !== {1'b1, 5'd5, 5'd7}) begin err_cnt++; $display("FAIL lu_capture: got %b %0d %0d want 1 5 7", ex_valid, ex_rs, ex_write_reg); end
  endtask

  task automatic test_branch_on_load();
    set_lw(5'd0, 5'd8, 32'h8);
    next_cycle();
    set_beq(5'd8, 5'd9);
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL bl_stall1: got %b want 1", stall); end
    next_cycle(); #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL bl_stall2: got %b want 1", stall); end
    vec_cnt++; if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL bl_bubble1: got %b want 0", ex_valid); end
    next_cycle(); #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL bl_stall_end: got %b want 0", stall); end
    vec_cnt++; if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL bl_bubble2: got %b want 0", ex_valid); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_rs, ex_rt, ex_regwrite, ex_write_reg} !== {1'b1, 5'd8, 5'd9, 1'b0, 5'd9}) begin err_cnt++; $display("FAIL bl_capture: got %b %0d %0d %b %0d want 1 8 9 0 9", ex_valid, ex_rs, ex_rt, ex_regwrite, ex_write_reg); end
  endtask

  task automatic test_reg0();
    set_lw(5'd0, 5'd0, 32'h0);
    next_cycle();
    set_alu(5'd0, 5'd0, 5'd3, 32'h0, 32'h0);
    #1;
    vec_cnt++; if ({ex_valid, ex_memread, ex_write_reg} !== {1'b1, 1'b1, 5'd0}) begin err_cnt++; $display("FAIL r0_lw_in_ex: got %b %b %0d want 1 1 0", ex_valid, ex_memread, ex_write_reg); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL r0_lu_stall: got %b want 0", stall); end
    id_branch = 1'b1;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL r0_bh_stall: got %b want 0", stall); end
    id_branch = 1'b0;
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_write_reg} !== {1'b1, 5'd3}) begin err_cnt++; $display("FAIL r0_capture: got %b %0d want 1 3", ex_valid, ex_write_reg); end
  endtask

  task automatic test_flush();
    set_lw(5'd1, 5'd8, 32'h10);
    next_cycle();
    set_beq(5'd8, 5'd9);
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL fl_stall1: got %b want 1", stall); end
    next_cycle();
    flush = 1'b1;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL fl_stall2_flush: got %b want 0", stall); end
    next_cycle();
    flush = 1'b0;
    #1;
    vec_cnt++; if (ex_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_bubble: got %b want 0", ex_valid); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL fl_back_in_run: got %b want 0", stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_rs} !== {1'b1, 5'd8}) begin err_cnt++; $display("FAIL fl_capture: got %b %0d want 1 8", ex_valid, ex_rs); end
    // flush and hold together: bubble wins over freeze
    idle_id();
    flush = 1'b1; hold = 1'b1;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL flhold_stall: got %b want 0", stall); end
    next_cycle();
    idle_id();
    #1;
    vec_cnt++; if ({ex_valid, ex_rs, ex_rt} !== 11'd0) begin err_cnt++; $display("FAIL flhold_bubble: got %b %0d %0d want 0 0 0", ex_valid, ex_rs, ex_rt); end
  endtask

  task automatic test_hold();
    set_lw(5'd0, 5'd5, 32'h40);
    next_cycle();
    set_alu(5'd5, 5'd6, 5'd7, 32'h1, 32'h2);
    hold = 1'b1;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL hold_stall0: got %b want 1", stall); end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      vec_cnt++; if ({ex_valid, ex_memread, ex_write_reg, ex_imm} !== {1'b1, 1'b1, 5'd5, 32'h40}) begin err_cnt++; $display("FAIL hold_frozen%0d: got %b %b %0d %h want 1 1 5 40", i, ex_valid, ex_memread, ex_write_reg, ex_imm); end
      vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL hold_stall%0d: got %b want 1", i + 1, stall); end
    end
    next_cycle();
    hold = 1'b0;
    #1;
    vec_cnt++; if ({ex_valid, ex_write_reg, ex_imm} !== {1'b1, 5'd5, 32'h40}) begin err_cnt++; $display("FAIL hold_frozen_end: got %b %0d %h want 1 5 40", ex_valid, ex_write_reg, ex_imm); end
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL hold_retrigger: got %b want 1", stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, stall} !== 2'b00) begin err_cnt++; $display("FAIL hold_lu_bubble: got valid=%b stall=%b want 0 0", ex_valid, stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_write_reg} !== {1'b1, 5'd7}) begin err_cnt++; $display("FAIL hold_capture: got %b %0d want 1 7", ex_valid, ex_write_reg); end
  endtask

  task automatic test_back_to_back();
    set_lw(5'd0, 5'd10, 32'h0);
    next_cycle();
    set_lw(5'd10, 5'd11, 32'h4);
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL b2b_stall1: got %b want 1", stall); end
    next_cycle(); #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_gap: got %b want 0", stall); end
    next_cycle();
    set_alu(5'd11, 5'd0, 5'd12, 32'h0, 32'h0);
    id_uses_rt = 1'b0;
    #1;
    vec_cnt++; if ({ex_valid, ex_write_reg} !== {1'b1, 5'd11}) begin err_cnt++; $display("FAIL b2b_lw2: got %b %0d want 1 11", ex_valid, ex_write_reg); end
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL b2b_stall2: got %b want 1", stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, stall} !== 2'b00) begin err_cnt++; $display("FAIL b2b_bubble2: got valid=%b stall=%b want 0 0", ex_valid, stall); end
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_write_reg} !== {1'b1, 5'd12}) begin err_cnt++; $display("FAIL b2b_capture: got %b %0d want 1 12", ex_valid, ex_write_reg); end
  endtask

  task automatic test_reset_mid_stall();
    set_lw(5'd0, 5'd5, 32'h0);
    next_cycle();
    set_alu(5'd5, 5'd6, 5'd7, 32'h0, 32'h0);
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if ({stall, ex_valid, ex_write_reg, ex_memread} !== 8'd0) begin err_cnt++; $display("FAIL rst_async: got stall=%b valid=%b wreg=%0d mr=%b want 0", stall, ex_valid, ex_write_reg, ex_memread); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle(); #1;
    vec_cnt++; if ({ex_valid, ex_write_reg} !== {1'b1, 5'd7}) begin err_cnt++; $display("FAIL rst_release_capture: got %b %0d want 1 7", ex_valid, ex_write_reg); end
  endtask

  initial begin
    idle_id();
    test_reset();
    test_plain_capture();
    test_load_use();
    test_branch_on_load();
    test_reg0();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
